jk_bank_arbiter: RTL and testbench

//   Shares a WIDTH-bit bank of jk_ff flip-flops between NREQ requesters.

---
 rtl/jk_bank_arbiter.sv | 161 ++++++++++++++++
 tb/tb_jk_bank_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: round-robin access to a shared bank of jk_ff bits.
// One command per three cycles: grant, drive J/K, settle, report.
module jk_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDXW  = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [2*NREQ-1:0]        req_op,
  input  logic [IDXW*NREQ-1:0]     req_idx,
  output logic [NREQ-1:0]          req_ready,
  output logic [WIDTH-1:0]         jk_j,
  output logic [WIDTH-1:0]         jk_k,
  input  logic [WIDTH-1:0]         bank_q,
  output logic                     done_valid,
  output logic [$clog2(NREQ)-1:0]  done_id,
  output logic                     done_q,
  output logic                     done_err
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_DRIVE,
    S_SETTLE
  } state_t;

  state_t          r_state;
  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  r_id;
  logic [1:0]      r_op;
  logic [IDXW-1:0] r_idx;

  logic [IDW-1:0]  w_win;
  logic [IDW-1:0]  w_nxt;
  logic [IDW-1:0]  w_c;
  logic [IDW:0]    w_s;
  logic            w_any;
  logic [1:0]      w_op;
  logic [IDXW-1:0] w_idx;
  logic            w_hit;
  logic            w_bit;

  // Winner search: first valid requester at or above the pointer, wrapping at NREQ.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_s   = '0;
    w_c   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      w_s = {1'b0, r_ptr} + (IDW+1)'(i);
      if (w_s >= (IDW+1)'(NREQ)) begin
        w_s = w_s - (IDW+1)'(NREQ);
      end
      w_c = w_s[IDW-1:0];
      if (req_valid[w_c]) begin
        w_any = 1'b1;
        w_win = w_c;
      end
    end
  end

  // Command fields of the winner and the pointer value that follows it.
  always_comb begin
    w_op  = '0;
    w_idx = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (IDW'(j) == w_win) begin
        w_op  = req_op[2*j +: 2];
        w_idx = req_idx[IDXW*j +: IDXW];
      end
    end
    w_nxt = (w_win == IDW'(NREQ - 1)) ? '0 : w_win + IDW'(1);
  end

  // Grant is one-hot on the winner, only while idle.
  always_comb begin
    req_ready = '0;
    if (r_state == S_IDLE && w_any) begin
      req_ready[w_win] = 1'b1;
    end
  end

  // J/K decode from state and latched command; bank bit lookup for reporting.
  always_comb begin
    jk_j  = '0;
    jk_k  = '0;
    w_hit = 1'b0;
    w_bit = 1'b0;
    for (int b = 0; b < WIDTH; b++) begin
      if (r_idx == IDXW'(b)) begin
        w_hit = 1'b1;
        w_bit = bank_q[b];
      end
    end
    unique case (r_state)
      S_INIT: begin
        jk_k = '1;
      end
      S_DRIVE: begin
        for (int b = 0; b < WIDTH; b++) begin
          if (r_idx == IDXW'(b)) begin
            jk_j[b] = r_op[1];
            jk_k[b] = r_op[0];
          end
        end
      end
      default: begin
      end
    endcase
  end

  // Sequencer: init clear, grant, drive, settle, then report completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_INIT;
      r_ptr      <= '0;
      r_id       <= '0;
      r_op       <= '0;
      r_idx      <= '0;
      done_valid <= 1'b0;
      done_id    <= '0;
      done_q     <= 1'b0;
      done_err   <= 1'b0;
    end else begin
      done_valid <= 1'b0;
      unique case (r_state)
        S_INIT: begin
          r_state <= S_IDLE;
        end
        S_IDLE: begin
          if (w_any) begin
            r_op    <= w_op;
            r_idx   <= w_idx;
            r_id    <= w_win;
            r_ptr   <= w_nxt;
            r_state <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          r_state <= S_SETTLE;
        end
        S_SETTLE: begin
          done_valid <= 1'b1;
          done_id    <= r_id;
          done_q     <= w_hit & w_bit;
          done_err   <= ~w_hit;
          r_state    <= S_IDLE;
        end
        default: begin
          r_state <= S_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// tb_jk_bank_arbiter: directed table, corner sequences and a randomized
// run against a transaction-level model of the arbiter and jk bank.
module tb_jk_bank_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b1;
  logic seed;
  logic [7:0] seedval;

  logic [3:0]  v8;
  logic [7:0]  op8;
  logic [11:0] ix8;
  logic [3:0]  rdy8;
  logic [7:0]  j8, k8, q8;
  logic        dv8, dq8, de8;
  logic [1:0]  did8;

  logic [3:0]  v6;
  logic [7:0]  op6;
  logic [11:0] ix6;
  logic [3:0]  rdy6;
  logic [5:0]  j6, k6, q6;
  logic        dv6, dq6, de6;
  logic [1:0]  did6;

  jk_bank_arbiter #(.NREQ(4), .WIDTH(8), .IDXW(3)) u8 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(v8), .req_op(op8), .req_idx(ix8),
    .req_ready(rdy8), .jk_j(j8), .jk_k(k8), .bank_q(q8),
    .done_valid(dv8), .done_id(did8), .done_q(dq8), .done_err(de8)
  );

  jk_bank_arbiter #(.NREQ(4), .WIDTH(6), .IDXW(3)) u6 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(v6), .req_op(op6), .req_idx(ix6),
    .req_ready(rdy6), .jk_j(j6), .jk_k(k6), .bank_q(q6),
    .done_valid(dv6), .done_id(did6), .done_q(dq6), .done_err(de6)
  );

  function automatic logic jkf(input logic q, input logic j, input logic k);
    case ({j, k})
      2'b00:   return q;
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      default: return ~q;
    endcase
  endfunction

  // jk_ff banks; seed forces a garbage power-up value
  always @(posedge clk) begin
    if (seed) begin
      q8 <= seedval;
      q6 <= seedval[5:0];
    end else begin
      for (int b = 0; b < 8; b++) q8[b] <= jkf(q8[b], j8[b], k8[b]);
      for (int b = 0; b < 6; b++) q6[b] <= jkf(q6[b], j6[b], k6[b]);
    end
  end

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    v8 = '0;
    v6 = '0;
    seed = 1'b1;
    seedval = 8'($urandom) | 8'h81;
    repeat (n) tick();
    chk("rst_jk_k", 32'(k8), 32'hFF);
    chk("rst_jk_j", 32'(j8), 32'h0);
    chk("rst_ready", 32'(rdy8), 32'h0);
    chk("rst_done_valid", 32'(dv8), 32'h0);
    chk("rst_done_id", 32'(did8), 32'h0);
    chk("rst_jk_k6", 32'(k6), 32'h3F);
    rst_n = 1'b1;
    seed = 1'b0;
    tick();
    chk("init_jk_k", 32'(k8), 32'h0);
    chk("init_bank", 32'(q8), 32'h0);
    chk("init_bank6", 32'(q6), 32'h0);
  endtask

  typedef struct {
    int         rid;
    logic [1:0] op;
    logic [2:0] idx;
    logic [7:0] ej;
    logic [7:0] ek;
    logic       eq;
  } vec_t;

  vec_t tbl[8];

  task automatic run_vec(input vec_t t);
    v8 = 4'b0001 << t.rid;
    op8[2*t.rid +: 2] = t.op;
    ix8[3*t.rid +: 3] = t.idx;
    #1;
    chk("tbl_ready", 32'(rdy8), 32'(4'b0001 << t.rid));
    tick();
    v8 = '0;
    chk("tbl_drive_j", 32'(j8), 32'(t.ej));
    chk("tbl_drive_k", 32'(k8), 32'(t.ek));
    tick();
    chk("tbl_settle_jk", 32'({j8, k8}), 32'h0);
    chk("tbl_settle_dv", 32'(dv8), 32'h0);
    tick();
    chk("tbl_done_valid", 32'(dv8), 32'h1);
    chk("tbl_done_id", 32'(did8), 32'(t.rid));
    chk("tbl_done_q", 32'(dq8), 32'(t.eq));
    chk("tbl_done_err", 32'(de8), 32'h0);
  endtask

  typedef struct {
    int   due;
    int   id;
    logic q;
  } dn_t;

  initial begin
    logic [7:0] mbank;
    int ptr, busy, win;
    logic [3:0] erdy;
    logic [1:0] mop;
    logic [2:0] midx;
    logic nb;
    dn_t pend[$];
    dn_t d;
    bit granted;

    seed = 1'b0;
    seedval = '0;
    v8 = '0; op8 = '0; ix8 = '0;
    v6 = '0; op6 = '0; ix6 = '0;

    tbl[0] = '{0, 2'b10, 3'd5, 8'h20, 8'h00, 1'b1};
    tbl[1] = '{1, 2'b11, 3'd2, 8'h04, 8'h04, 1'b1};
    tbl[2] = '{1, 2'b11, 3'd2, 8'h04, 8'h04, 1'b0};
    tbl[3] = '{3, 2'b01, 3'd5, 8'h00, 8'h20, 1'b0};
    tbl[4] = '{2, 2'b00, 3'd7, 8'h00, 8'h00, 1'b0};
    tbl[5] = '{2, 2'b10, 3'd7, 8'h80, 8'h00, 1'b1};
    tbl[6] = '{0, 2'b00, 3'd7, 8'h00, 8'h00, 1'b1};
    tbl[7] = '{1, 2'b11, 3'd0, 8'h01, 8'h01, 1'b1};

    do_reset(3);

    for (int i = 0; i < 8; i++) run_vec(tbl[i]);

    // toggle held valid: handshakes three cycles apart
    v8 = 4'b0010;
    op8[3:2] = 2'b11;
    ix8[5:3] = 3'd2;
    #1;
    chk("tgl_ready0", 32'(rdy8), 32'h2);
    tick();
    chk("tgl_gap1", 32'(rdy8), 32'h0);
    tick();
    chk("tgl_gap2", 32'(rdy8), 32'h0);
    tick();
    chk("tgl_ready1", 32'(rdy8), 32'h2);
    chk("tgl_done1_v", 32'(dv8), 32'h1);
    chk("tgl_done1_q", 32'(dq8), 32'h1);
    tick();
    v8 = '0;
    tick();
    tick();
    chk("tgl_done2_v", 32'(dv8), 32'h1);
    chk("tgl_done2_q", 32'(dq8), 32'h0);

    // out-of-range index on the 6-bit bank, then a legal one
    v6 = 4'b0100;
    op6[5:4] = 2'b10;
    ix6[8:6] = 3'd7;
    #1;
    chk("bad_ready", 32'(rdy6), 32'h4);
    tick();
    v6 = '0;
    chk("bad_drive_jk", 32'({j6, k6}), 32'h0);
    tick();
    tick();
    chk("bad_done_v", 32'(dv6), 32'h1);
    chk("bad_done_err", 32'(de6), 32'h1);
    chk("bad_done_q", 32'(dq6), 32'h0);
    chk("bad_done_id", 32'(did6), 32'h2);
    v6 = 4'b0100;
    ix6[8:6] = 3'd5;
    #1;
    chk("w6_ready", 32'(rdy6), 32'h4);
    tick();
    v6 = '0;
    chk("w6_drive_j", 32'(j6), 32'h20);
    tick();
    tick();
    chk("w6_done_err", 32'(de6), 32'h0);
    chk("w6_done_q", 32'(dq6), 32'h1);
    chk("w6_bank", 32'(q6), 32'h20);

    // round robin with all requesters held valid
    do_reset(2);
    op8 = '0;
    ix8 = '0;
    v8 = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_grant", 32'(rdy8), 32'(4'b0001 << (k % 4)));
      tick();
      chk("rr_onehot1", 32'($onehot0(rdy8)), 32'h1);
      chk("rr_idle1", 32'(rdy8), 32'h0);
      tick();
      chk("rr_idle2", 32'(rdy8), 32'h0);
      tick();
    end
    v8 = '0;

    // reset asserted during DRIVE of req3
    do_reset(2);
    v8 = 4'b1000;
    op8[7:6] = 2'b10;
    ix8[11:9] = 3'd4;
    #1;
    chk("mid_ready", 32'(rdy8), 32'h8);
    tick();
    chk("mid_drive_j", 32'(j8), 32'h10);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_k", 32'(k8), 32'hFF);
    chk("mid_rst_j", 32'(j8), 32'h0);
    chk("mid_rst_ready", 32'(rdy8), 32'h0);
    tick();
    tick();
    chk("mid_rst_dv", 32'(dv8), 32'h0);
    chk("mid_rst_bank", 32'(q8), 32'h0);
    rst_n = 1'b1;
    v8 = 4'b1001;
    op8[1:0] = 2'b10;
    ix8[2:0] = 3'd1;
    #1;
    chk("mid_init_ready", 32'(rdy8), 32'h0);
    tick();
    chk("mid_first_grant", 32'(rdy8), 32'h1);
    tick();
    v8 = 4'b1000;
    chk("mid_no_done1", 32'(dv8), 32'h0);
    tick();
    chk("mid_no_done2", 32'(dv8), 32'h0);
    tick();
    chk("mid_done_v", 32'(dv8), 32'h1);
    chk("mid_done_id", 32'(did8), 32'h0);
    chk("mid_done_q", 32'(dq8), 32'h1);
    chk("mid_next_grant", 32'(rdy8), 32'h8);
    tick();
    v8 = '0;
    tick();
    tick();

    // randomized traffic against a transaction-level model
    do_reset(2);
    mbank = '0;
    ptr = 0;
    busy = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int r = 0; r < 4; r++) begin
        if (cyc >= 596) begin
          v8[r] = 1'b0;
        end else if (!v8[r]) begin
          if ($urandom_range(0, 2) == 0) begin
            v8[r] = 1'b1;
            op8[2*r +: 2] = 2'($urandom);
            ix8[3*r +: 3] = 3'($urandom);
          end
        end else if ($urandom_range(0, 15) == 0) begin
          v8[r] = 1'b0;
        end
      end
      #1;
      erdy = '0;
      win = 0;
      if (cyc >= busy) begin
        for (int i = 3; i >= 0; i--) begin
          if (v8[(ptr + i) % 4]) win = (ptr + i) % 4;
        end
        if (v8 != 0) erdy[win] = 1'b1;
      end
      chk("rnd_ready", 32'(rdy8), 32'(erdy));
      if (pend.size() > 0 && pend[0].due == cyc) begin
        d = pend.pop_front();
        chk("rnd_done_v", 32'(dv8), 32'h1);
        chk("rnd_done_id", 32'(did8), 32'(d.id));
        chk("rnd_done_q", 32'(dq8), 32'(d.q));
        chk("rnd_bank", 32'(q8), 32'(mbank));
      end else begin
        chk("rnd_no_done", 32'(dv8), 32'h0);
      end
      granted = (erdy != 0);
      if (granted) begin
        mop = op8[2*win +: 2];
        midx = ix8[3*win +: 3];
        nb = jkf(mbank[midx], mop[1], mop[0]);
        mbank[midx] = nb;
        pend.push_back('{cyc + 3, win, nb});
        ptr = (win + 1) % 4;
        busy = cyc + 3;
      end
      tick();
      if (granted) v8[win] = 1'b0;
    end
    chk("rnd_drained", 32'(pend.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
